tile_rd_stream: RTL
===================

Name: tile_rd_stream

Overview:
- Read-side engine for a tile buffer (simple dual-port RAM, registered read, 1-cycle latency, read data holds while rd_en low).
- Accepts a tile-walk command (base, rows, cols, row stride) and issues buffer read addresses in row-major order.
- Returns the words as a valid/ready stream with row-end and tile-end markers.
- Sits between tile buffers and the compute-array input; absorbs RAM latency and downstream backpressure with an internal credit-limited FIFO.

Parameters:
- DATA_W, 8, word width; matches the tile buffer.
- DEPTH, 4096, tile buffer depth in words.
- ADDR_W, (DEPTH<=1)?1:$clog2(DEPTH), buffer address width.
- DIM_W, 8, width of the row/col count fields.
- FIFO_DEPTH, 4, output FIFO entries; must be >=3 (elaboration assertion).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  ADDR_W  address of element (0,0).
- cmd_rows  in  DIM_W  row count.
- cmd_cols  in  DIM_W  column count.
- cmd_stride  in  ADDR_W  address step between row starts.
- buf_rd_en  out  1  buffer read enable.
- buf_rd_addr  out  ADDR_W  buffer read address.
- buf_rd_data  in  DATA_W  buffer read data, valid the cycle after buf_rd_en.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_W  element.
- out_row_last  out  1  last column of the current row.
- out_last  out  1  final element of the tile.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at tile completion.

Behaviour:
- Reset (async, any time, including mid-tile) forces:
  - State IDLE; FIFO emptied; in-flight flag cleared; all counters 0.
  - Outputs: cmd_ready=1, buf_rd_en=0, buf_rd_addr=0, out_valid=0, out_data=0, out_row_last=0, out_last=0, busy=0, done=0.
  - Any partial tile is discarded.
- States:
  - IDLE: on cmd_valid&&cmd_ready, latch the command and reset row/col counters. Next state is RUN, or ZERO if rows==0 or cols==0.
  - ZERO: issues no reads and emits no beats. Pulse done, then go to IDLE.
  - RUN: issues reads. After the final read is issued, go to DRAIN.
  - DRAIN: wait until in-flight==0 and the FIFO is empty after the out_last handshake. Pulse done in the following cycle, then go to IDLE.
- Address generation:
  - Address is row_ptr+col.
  - On the last column: col<=0 and row_ptr<=row_ptr+stride.
  - All address arithmetic is modulo 2^ADDR_W (wrap, no error).
- Read issue:
  - buf_rd_en=1 in RUN only when fifo_count + inflight + 1 <= FIFO_DEPTH. This is conservative; same-cycle pops are not counted.
  - inflight is a 1-bit register set on the cycle a read issues.
  - When inflight=1, buf_rd_data is written to the FIFO that cycle, together with the row_last/last tags carried in a 2-bit sideband register.
- Latency:
  - Command accepted at the end of cycle T.
  - First buf_rd_en in T+1.
  - First out_valid in T+3.
  - With out_ready held high: 1 beat/cycle sustained, no bubbles after the first.
- Stream rules:
  - out_valid/out_data/tags come from the FIFO head.
  - Once out_valid is asserted, it and the payload stay stable until out_ready.
  - A FIFO push and pop in the same cycle is legal at any count, including full.
- Tags:
  - out_row_last=1 when col==cols-1.
  - out_last=1 when both row==rows-1 and col==cols-1.
- done: rises exactly one cycle after the out_last handshake (or one cycle after ZERO is entered). It is 0 at all other times.
- New commands are ignored while busy (cmd_ready=0).

Decomposition:
- Shared package tile_pkg:
  - State enum (IDLE, RUN, DRAIN, ZERO).
  - Sideband tag struct {row_last, last}.
  - Default DATA_W/ADDR_W constants shared with the tile buffer.
- Sub-module stream_fifo: synchronous FIFO with parameterised DATA_W+2 width and FIFO_DEPTH, count output, same clock/reset.

Test Plan:
- Base=0, rows=2, cols=3, stride=8, out_ready=1; buffer preloaded mem[a]=a:
  - Addresses issued: 0,1,2,8,9,10.
  - Data out: 0,1,2,8,9,10.
  - row_last on beats 3 and 6; out_last on beat 6.
  - First out_valid at T+3; done one cycle after beat 6.
- Same tile with out_ready toggling 1,0,0,1 repeatedly:
  - Data order and tags unchanged; payload stable while stalled.
  - buf_rd_en never issued when count+inflight=FIFO_DEPTH-... limit is reached (FIFO never overflows).
- Base=4094, rows=1, cols=4, DEPTH=4096: addresses 4094,4095,0,1 (wrap).
- rows=0, cols=5: no buf_rd_en, no out_valid; done pulses once at T+2; cmd_ready=1 again at T+2.
- rst_n deasserted mid-tile (after 3 beats, FIFO non-empty):
  - All outputs zero immediately.
  - After release, a new 1x1 command at base 7 yields a single beat of data 7 with row_last=last=1.
- cmd_valid held high during busy: second command accepted only in the cycle after done; its stream starts cleanly after the first tile.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types and default widths for the tile read-stream engine and its tile buffers.
package tile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4096;
  localparam int DEF_DIM_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ZERO  = 2'd3
  } state_t;

  typedef struct packed {
    logic row_last;
    logic last;
  } tag_t;

endpackage

// File: rtl/tile_rd_stream_if.sv
// Command, buffer-read and output-stream signals of the tile read engine.
interface tile_rd_stream_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [DIM_W-1:0]  cmd_rows;
  logic [DIM_W-1:0]  cmd_cols;
  logic [ADDR_W-1:0] cmd_stride;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_row_last;
  logic              out_last;

  // master: the engine; slave: command source, tile buffer and stream sink
  modport master (
    input  cmd_valid, cmd_base, cmd_rows, cmd_cols, cmd_stride, buf_rd_data, out_ready,
    output cmd_ready, buf_rd_en, buf_rd_addr, out_valid, out_data, out_row_last, out_last
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_rows, cmd_cols, cmd_stride, buf_rd_data, out_ready,
    input  cmd_ready, buf_rd_en, buf_rd_addr, out_valid, out_data, out_row_last, out_last
  );
endinterface

// File: rtl/tile_rd_stream_fifo.sv
// Synchronous FIFO with combinational head read; push and pop together are legal even when full.
module stream_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/tile_rd_stream.sv
// Tile read engine: walks a rows x cols tile in row-major order and streams the words out
// through a credit-limited FIFO that hides the buffer read latency and downstream stalls.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing buffer reads as FIFO credit allows
// DRAIN | all reads issued, waiting for the out_last handshake, then done
// ZERO  | empty tile (rows or cols zero), pulse done only
module tile_rd_stream
  import tile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  parameter int DIM_W      = DEF_DIM_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tile_rd_stream_if.master      bus,
  output logic                  busy,
  output logic                  done
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  if (FIFO_DEPTH < 3) begin : g_bad_fifo_depth
    $error("tile_rd_stream: FIFO_DEPTH must be at least 3");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_ptr_q, row_ptr_d, stride_q, stride_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d, rows_q, rows_d, cols_q, cols_d;
  logic              inflight_q, done_q, done_d;
  tag_t              tag_q, rd_tag, head_tag;
  logic              rd_en, credit_ok, fifo_pop, fifo_valid;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W+1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  // Pops in the same cycle are not credited back, keeping the check purely registered
  assign credit_ok = (32'(fifo_count) + 32'(inflight_q) + 32'd1) <= 32'(FIFO_DEPTH);
  assign rd_tag.row_last = (col_q == cols_q - DIM_W'(1));
  assign rd_tag.last     = rd_tag.row_last && (row_q == rows_q - DIM_W'(1));

  assign fifo_valid = (fifo_count != '0);
  assign fifo_pop   = fifo_valid && bus.out_ready;
  assign {head_tag, head_data} = fifo_rdata;

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    stride_d  = stride_q;
    row_d     = row_q;
    col_d     = col_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    rd_en     = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          row_ptr_d = bus.cmd_base;
          stride_d  = bus.cmd_stride;
          rows_d    = bus.cmd_rows;
          cols_d    = bus.cmd_cols;
          row_d     = '0;
          col_d     = '0;
          state_d   = (bus.cmd_rows == '0 || bus.cmd_cols == '0) ? ZERO : RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (rd_tag.row_last) begin
            col_d     = '0;
            row_d     = row_q + DIM_W'(1);
            row_ptr_d = row_ptr_q + stride_q;
            if (rd_tag.last) state_d = DRAIN;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      DRAIN: begin
        if (done_q)                            state_d = IDLE;
        else if (fifo_pop && head_tag.last)    done_d  = 1'b1;
      end
      ZERO: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_ptr_q  <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_ptr_q  <= row_ptr_d;
      stride_q   <= stride_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      inflight_q <= rd_en;
      if (rd_en) tag_q <= rd_tag;
      done_q     <= done_d;
    end
  end

  stream_fifo #(.WIDTH(DATA_W+2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i ({tag_q, bus.buf_rd_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.buf_rd_en    = rd_en;
  assign bus.buf_rd_addr  = rd_en ? (row_ptr_q + ADDR_W'(col_q)) : '0;
  assign bus.out_valid    = fifo_valid;
  assign bus.out_data     = fifo_valid ? head_data : '0;
  assign bus.out_row_last = fifo_valid && head_tag.row_last;
  assign bus.out_last     = fifo_valid && head_tag.last;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
endmodule
